// File: rtl/ttl_74161_pkg.sv
// ttl_74161_pkg: terminal-count constants shared by the 74161/74160 counter.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package ttl_74161_pkg;

  // Decade (74160-style) counting is only defined for a 4-bit counter.
  localparam int          DECADE_WIDTH = 4;
  localparam logic [3:0]  DECADE_TC    = 4'd9;

  // Binary terminal count: all ones of the requested width.
  function automatic logic [31:0] bin_tc(input int w);
    bin_tc = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/ttl_74161.sv
// ttl_74161: presettable synchronous counter, async clear, sync load, ENP/ENT, ripple carry.
// Latency: Q updates 1 Clk edge after load/count; clear is immediate; RCO is combinational.
// Backpressure: none; stages cascade by wiring RCO of stage n to ENT of stage n+1.
//
// Ports:
//   Clk        rising-edge counter clock
//   Clear_bar  asynchronous active-low clear (highest priority)
//   Load_bar   synchronous active-low parallel load of D (beats counting)
//   ENP, ENT   count enables; ENT also gates RCO
//   D          parallel load data
//   Q          counter state
//   RCO        ENT & (Q == terminal count), forced low during clear
//
// Build option: define TTL_74161_DECADE_EN for decade counting (0..9, TC = 9,
// WIDTH must be 4). Undefined: binary modulo 2^WIDTH, TC = all ones.
// DELAY_RISE/DELAY_FALL describe the part's output timing for board-level
// models; this netlist itself is zero-delay.
module ttl_74161
  import ttl_74161_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic             Clk,
  input  logic             Clear_bar,
  input  logic             Load_bar,
  input  logic             ENP,
  input  logic             ENT,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

`ifdef TTL_74161_DECADE_EN
  localparam bit DECADE_MODE = 1'b1;
`else
  localparam bit DECADE_MODE = 1'b0;
`endif

  localparam logic [WIDTH-1:0] TC  = DECADE_MODE ? WIDTH'(DECADE_TC) : WIDTH'(bin_tc(WIDTH));
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Elaboration-time sanity checks.
  if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
    $error("ttl_74161: DELAY_RISE/DELAY_FALL must be non-negative");
  end

`ifdef TTL_74161_DECADE_EN
  if (WIDTH != DECADE_WIDTH) begin : g_bad_width
    $error("ttl_74161: decade mode requires WIDTH == 4");
  end
`endif

  logic [WIDTH-1:0] r_q;

  // Priority: clear (async), load, count, hold.
  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      r_q <= '0;
    end else if (!Load_bar) begin
      r_q <= D;
    end else if (ENP && ENT) begin
`ifdef TTL_74161_DECADE_EN
      // 9 wraps to 0; illegal loaded codes 10..15 also return to 0.
      r_q <= (r_q >= TC) ? '0 : r_q + ONE;
`else
      // Carry out of the top bit is discarded: all ones wraps to 0.
      r_q <= r_q + ONE;
`endif
    end
  end

  assign Q = r_q;

  // Clear_bar term keeps RCO low during clear without waiting on r_q.
  assign RCO = Clear_bar & ENT & (r_q == TC);

endmodule
